// File: rtl/bp_be_pkg.sv
// Backend shared types: issue-slot fields and pending-counter limits for the dual-issue scoreboard.
package bp_be_pkg;

   localparam int sb_addr_width     = 5;
   localparam int sb_max_read_ports = 3;
   localparam int sb_cnt_width      = 2;
   localparam int sb_max_cnt        = (1 << sb_cnt_width) - 1;

   // Source fields above the configured read-port count are tied off to zero.
   typedef struct packed {
      logic [sb_max_read_ports-1:0]                    rs_v;
      logic [sb_max_read_ports-1:0][sb_addr_width-1:0] rs_addr;
      logic                                            rd_w_v;
      logic [sb_addr_width-1:0]                        rd_addr;
   } bp_be_sb_slot_s;

endpackage

// File: rtl/bp_be_sb_hazard.sv
// Per-slot hazard evaluation against the scoreboard counters, with same-cycle writeback forwarding.
module bp_be_sb_hazard
   import bp_be_pkg::*;
#(
   parameter int cnt_width_p = sb_cnt_width,
   parameter int zero_x0_p   = 1
) (
   input  logic [(1<<sb_addr_width)-1:0][cnt_width_p-1:0] cnt_i,
   input  logic [1:0]                                     wb_w_v_i,
   input  logic [1:0][sb_addr_width-1:0]                  wb_addr_i,
   input  bp_be_sb_slot_s                                 slot_i,
   output logic                                           raw_o,
   output logic                                           waw_o,
   output logic                                           sat_o
);

   localparam int nregs_lp = 1 << sb_addr_width;

   logic [nregs_lp-1:0] w_eff_nz;
   logic                w_rd_x0;

   // Effective count is nonzero only if outstanding writes exceed this cycle's writebacks.
   always_comb begin
      for (int r = 0; r < nregs_lp; r++) begin
         logic [1:0] v_wbn;
         v_wbn = {1'b0, (wb_w_v_i[0] && (wb_addr_i[0] == sb_addr_width'(r)))}
               + {1'b0, (wb_w_v_i[1] && (wb_addr_i[1] == sb_addr_width'(r)))};
         w_eff_nz[r] = ({2'b00, cnt_i[r]} > {{cnt_width_p{1'b0}}, v_wbn});
         if ((zero_x0_p != 0) && (r == 0)) w_eff_nz[r] = 1'b0;
      end
   end

   assign w_rd_x0 = (zero_x0_p != 0) && (slot_i.rd_addr == '0);

   // RAW over all source operands, WAW and saturation on the destination.
   always_comb begin
      raw_o = 1'b0;
      for (int i = 0; i < sb_max_read_ports; i++) begin
         if (slot_i.rs_v[i] && w_eff_nz[slot_i.rs_addr[i]]) raw_o = 1'b1;
      end
      waw_o = slot_i.rd_w_v && w_eff_nz[slot_i.rd_addr];
      sat_o = slot_i.rd_w_v && !w_rd_x0 && (cnt_i[slot_i.rd_addr] == {cnt_width_p{1'b1}});
   end

endmodule

// File: rtl/bp_be_dual_scoreboard.sv
// Dual-issue hazard scoreboard: per-register pending-write counters gate the two in-order issue slots.
// Optional perf counters (raw/waw stall, pair split) are built when BP_BE_SCOREBOARD_PERF_EN is defined.
// reg_addr_width_p must match the package address width used by the slot struct.
module bp_be_dual_scoreboard
   import bp_be_pkg::*;
#(
   parameter int reg_addr_width_p = sb_addr_width,
   parameter int read_ports_p     = 2,
   parameter int zero_x0_p        = 1,
   parameter int cnt_width_p      = sb_cnt_width
) (
   input  logic                                     clk_i,
   input  logic                                     reset_n_i,
   input  logic [1:0]                               issue_v_i,
   input  logic [2*read_ports_p-1:0]                issue_rs_v_i,
   input  logic [2*read_ports_p*reg_addr_width_p-1:0] issue_rs_addr_i,
   input  logic [1:0]                               issue_rd_w_v_i,
   input  logic [2*reg_addr_width_p-1:0]            issue_rd_addr_i,
   output logic [1:0]                               issue_yumi_o,
   input  logic [1:0]                               wb_w_v_i,
   input  logic [2*reg_addr_width_p-1:0]            wb_addr_i,
   input  logic                                     flush_i,
   output logic                                     pending_o,
   output logic                                     underflow_o
`ifdef BP_BE_SCOREBOARD_PERF_EN
  ,output logic [31:0]                              raw_stall_cnt_o,
   output logic [31:0]                              waw_stall_cnt_o,
   output logic [31:0]                              pair_split_cnt_o
`endif
);

   localparam int nregs_lp = 1 << reg_addr_width_p;

   logic [nregs_lp-1:0][cnt_width_p-1:0] r_cnt, w_cnt_nxt;
   logic                                 r_pending, r_uflow, w_uflow;
   bp_be_sb_slot_s [1:0]                 w_slot;
   logic [1:0][sb_addr_width-1:0]        w_wb_addr;
   logic [1:0]                           w_raw, w_waw, w_sat;
   logic                                 w_pair_dep, w_yumi0, w_yumi1;

   // Unpack the flat issue/writeback buses into per-slot fields.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         w_slot[s] = '0;
         for (int i = 0; i < read_ports_p; i++) begin
            w_slot[s].rs_v[i]    = issue_rs_v_i[s*read_ports_p+i];
            w_slot[s].rs_addr[i] = issue_rs_addr_i[(s*read_ports_p+i)*reg_addr_width_p +: reg_addr_width_p];
         end
         w_slot[s].rd_w_v  = issue_rd_w_v_i[s];
         w_slot[s].rd_addr = issue_rd_addr_i[s*reg_addr_width_p +: reg_addr_width_p];
         w_wb_addr[s]      = wb_addr_i[s*reg_addr_width_p +: reg_addr_width_p];
      end
   end

   for (genvar s = 0; s < 2; s++) begin : g_haz
      bp_be_sb_hazard #(
         .cnt_width_p (cnt_width_p),
         .zero_x0_p   (zero_x0_p)
      ) u_haz (
         .cnt_i     (r_cnt),
         .wb_w_v_i  (wb_w_v_i),
         .wb_addr_i (w_wb_addr),
         .slot_i    (w_slot[s]),
         .raw_o     (w_raw[s]),
         .waw_o     (w_waw[s]),
         .sat_o     (w_sat[s])
      );
   end

   // Slot 1 may not read or overwrite the register slot 0 is writing in the same pair.
   always_comb begin
      w_pair_dep = 1'b0;
      if (w_slot[0].rd_w_v && !((zero_x0_p != 0) && (w_slot[0].rd_addr == '0))) begin
         for (int i = 0; i < sb_max_read_ports; i++) begin
            if (w_slot[1].rs_v[i] && (w_slot[1].rs_addr[i] == w_slot[0].rd_addr)) w_pair_dep = 1'b1;
         end
         if (w_slot[1].rd_w_v && (w_slot[1].rd_addr == w_slot[0].rd_addr)) w_pair_dep = 1'b1;
      end
   end

   assign w_yumi0 = reset_n_i & issue_v_i[0] & ~w_raw[0] & ~w_waw[0] & ~w_sat[0] & ~flush_i;
   assign w_yumi1 = w_yumi0 & issue_v_i[1] & ~w_raw[1] & ~w_waw[1] & ~w_sat[1] & ~w_pair_dep;
   assign issue_yumi_o = {w_yumi1, w_yumi0};

   // Next counters: add accepted writes, subtract writebacks, clamp at zero and flag underflow.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_uflow   = 1'b0;
      for (int r = 0; r < nregs_lp; r++) begin
         logic [cnt_width_p+1:0] v_sum;
         logic [cnt_width_p+1:0] v_dec;
         v_sum = {2'b00, r_cnt[r]}
               + (cnt_width_p+2)'(w_yumi0 && w_slot[0].rd_w_v && (w_slot[0].rd_addr == sb_addr_width'(r)))
               + (cnt_width_p+2)'(w_yumi1 && w_slot[1].rd_w_v && (w_slot[1].rd_addr == sb_addr_width'(r)));
         v_dec = (cnt_width_p+2)'(wb_w_v_i[0] && (w_wb_addr[0] == sb_addr_width'(r)))
               + (cnt_width_p+2)'(wb_w_v_i[1] && (w_wb_addr[1] == sb_addr_width'(r)));
         if ((zero_x0_p != 0) && (r == 0)) begin
            w_cnt_nxt[r] = '0;
         end else if (v_sum < v_dec) begin
            w_cnt_nxt[r] = '0;
            w_uflow      = 1'b1;
         end else begin
            w_cnt_nxt[r] = cnt_width_p'(v_sum - v_dec);
         end
      end
      if (flush_i) begin
         w_cnt_nxt = '0;
         w_uflow   = 1'b0;
      end
   end

   // Counter state, registered pending summary and sticky underflow.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_cnt     <= '0;
         r_pending <= 1'b0;
         r_uflow   <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_pending <= |w_cnt_nxt;
         r_uflow   <= r_uflow | w_uflow;
      end
   end

   assign pending_o   = r_pending;
   assign underflow_o = r_uflow;

`ifdef BP_BE_SCOREBOARD_PERF_EN
   logic [31:0] r_raw_stall, r_waw_stall, r_pair_split;

   // Saturating event counters for stall diagnosis.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_raw_stall  <= '0;
         r_waw_stall  <= '0;
         r_pair_split <= '0;
      end else begin
         if (issue_v_i[0] && !flush_i && w_raw[0] && (r_raw_stall != '1)) r_raw_stall <= r_raw_stall + 32'd1;
         if (issue_v_i[0] && !flush_i && w_waw[0] && (r_waw_stall != '1)) r_waw_stall <= r_waw_stall + 32'd1;
         if (w_yumi0 && issue_v_i[1] && !w_yumi1 && (r_pair_split != '1)) r_pair_split <= r_pair_split + 32'd1;
      end
   end

   assign raw_stall_cnt_o  = r_raw_stall;
   assign waw_stall_cnt_o  = r_waw_stall;
   assign pair_split_cnt_o = r_pair_split;
`endif

endmodule
